// File: rtl/router_pkt_fifo_if.sv
// Handshake/data bundle between the router write path, the packet FIFO and the output channel.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface router_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  soft_reset;
  logic                  write_enb;
  logic                  read_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  pkt_end;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   occupancy;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, pkt_end, full, empty, almost_full,
           occupancy, overflow_err, underflow_err
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, pkt_end, full, empty, almost_full,
           occupancy, overflow_err, underflow_err
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO: header-marker bit per entry, packet-end tracking on reads.
// Define ROUTER_FIFO_ERR_EN to build the sticky overflow/underflow error flags.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 14
) (
  input  logic               clock,
  input  logic               reset,
  router_pkt_fifo_if.slave   bus
);
  localparam int LEN_W = DATA_WIDTH - 2;
  localparam int REM_W = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_occ;
  logic [REM_W-1:0]      r_rem_cnt;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_pkt_end;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH:0]   w_rd_entry;
  logic [LEN_W-1:0]      w_len;
  logic [REM_W-1:0]      w_len_plus1;

  assign w_full      = (r_occ == (ADDR_WIDTH+1)'(DEPTH));
  assign w_empty     = (r_occ == '0);
  // full/empty are taken from the registered count, so a read frees space only on the next cycle
  assign w_wr_acc    = bus.write_enb && !w_full && !bus.soft_reset;
  assign w_rd_acc    = bus.read_enb && !w_empty && !bus.soft_reset;
  assign w_rd_entry  = r_mem[r_rd_ptr];
  assign w_len       = w_rd_entry[DATA_WIDTH-1:2];
  assign w_len_plus1 = {1'b0, w_len} + REM_W'(1);

  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= {bus.lfd_state, bus.data_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_rem_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_pkt_end    <= 1'b0;
    end else if (bus.soft_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_rem_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_pkt_end    <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      r_pkt_end    <= 1'b0;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rd_entry[DATA_WIDTH-1:0];
        // A header always restarts the count, even if the previous packet was cut short
        if (w_rd_entry[DATA_WIDTH]) begin
          r_rem_cnt <= w_len_plus1;
        end else if (r_rem_cnt != '0) begin
          r_rem_cnt <= r_rem_cnt - 1'b1;
          r_pkt_end <= (r_rem_cnt == REM_W'(1));
        end
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_data_valid;
  assign bus.pkt_end     = r_pkt_end;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (r_occ >= (ADDR_WIDTH+1)'(AFULL_TH));
  assign bus.occupancy   = r_occ;

`ifdef ROUTER_FIFO_ERR_EN
  logic r_overflow_err;
  logic r_underflow_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (bus.write_enb && w_full)  r_overflow_err  <= 1'b1;
      if (bus.read_enb  && w_empty) r_underflow_err <= 1'b1;
    end
  end

  assign bus.overflow_err  = r_overflow_err;
  assign bus.underflow_err = r_underflow_err;
`else
  assign bus.overflow_err  = 1'b0;
  assign bus.underflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: packet flow, full/wrap, soft reset, underflow, zero-length packet.
module tb_router_pkt_fifo;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int AFULL_TH   = 14;
`ifdef ROUTER_FIFO_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  router_pkt_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  router_pkt_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .AFULL_TH  (AFULL_TH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    bus.write_enb = 1'b1;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    tick();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp_d, input logic exp_end);
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    check({tag, "_data"}, bus.data_out, exp_d);
    check({tag, "_valid"}, bus.data_valid, 1'b1);
    check({tag, "_pkt_end"}, bus.pkt_end, exp_end);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_pkt_end", bus.pkt_end, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_afull", bus.almost_full, 1'b0);
    check("rst_occ", bus.occupancy, 5'd0);
    check("rst_ovf", bus.overflow_err, 1'b0);
    check("rst_udf", bus.underflow_err, 1'b0);

    // Packet: header 0x31 (len 12), payload 0,5..55, parity 0xA5
    wr(8'h31, 1'b1);
    for (int i = 0; i < 12; i++) wr(8'(i * 5), 1'b0);
    check("pkt_occ13", bus.occupancy, 5'd13);
    check("pkt_afull13", bus.almost_full, 1'b0);
    wr(8'hA5, 1'b0);
    check("pkt_occ14", bus.occupancy, 5'd14);
    check("pkt_afull14", bus.almost_full, 1'b1);
    check("pkt_empty14", bus.empty, 1'b0);
    rd("pkt_hdr", 8'h31, 1'b0);
    for (int i = 0; i < 12; i++) rd("pkt_pay", 8'(i * 5), 1'b0);
    rd("pkt_par", 8'hA5, 1'b1);
    check("pkt_empty_after", bus.empty, 1'b1);
    check("pkt_occ_after", bus.occupancy, 5'd0);
    tick();
    check("hold_valid", bus.data_valid, 1'b0);
    check("hold_pkt_end", bus.pkt_end, 1'b0);
    check("hold_data", bus.data_out, 8'hA5);

    // Asynchronous reset mid-cycle
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check("arst_occ", bus.occupancy, 5'd0);
    check("arst_empty", bus.empty, 1'b1);
    check("arst_data", bus.data_out, 8'h00);
    #2;
    reset = 1'b0;
    tick();

    // Full and wrap
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
    check("full_flag", bus.full, 1'b1);
    check("full_occ", bus.occupancy, 5'd16);
    wr(8'hEE, 1'b0);
    check("ovf_occ", bus.occupancy, 5'd16);
    check("ovf_err", bus.overflow_err, ERR_ON);
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hEF;
    rd("rw_full", 8'h40, 1'b0);
    bus.write_enb = 1'b0;
    check("rw_full_occ", bus.occupancy, 5'd15);
    check("rw_full_flag", bus.full, 1'b0);
    wr(8'h50, 1'b0);
    check("wrap_occ", bus.occupancy, 5'd16);
    for (int i = 0; i < 15; i++) rd("wrap_rd", 8'h41 + 8'(i), 1'b0);
    rd("wrap_last", 8'h50, 1'b0);
    check("wrap_empty", bus.empty, 1'b1);

    // Soft reset mid-packet with a same-cycle write
    wr(8'h0D, 1'b1);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    rd("srst_hdr", 8'h0D, 1'b0);
    bus.soft_reset = 1'b1;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'h99;
    tick();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    check("srst_occ", bus.occupancy, 5'd0);
    check("srst_empty", bus.empty, 1'b1);
    check("srst_data", bus.data_out, 8'h00);
    check("srst_valid", bus.data_valid, 1'b0);
    wr(8'h05, 1'b1);
    wr(8'h33, 1'b0);
    wr(8'h5A, 1'b0);
    check("fresh_occ", bus.occupancy, 5'd3);
    rd("fresh_hdr", 8'h05, 1'b0);
    rd("fresh_pay", 8'h33, 1'b0);
    rd("fresh_par", 8'h5A, 1'b1);

    // Underflow
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    check("udf_valid", bus.data_valid, 1'b0);
    check("udf_data", bus.data_out, 8'h5A);
    check("udf_err", bus.underflow_err, ERR_ON);
    check("udf_ovf_sticky", bus.overflow_err, ERR_ON);

    // Zero-length packet
    wr(8'h02, 1'b1);
    wr(8'h7E, 1'b0);
    rd("zlen_hdr", 8'h02, 1'b0);
    rd("zlen_par", 8'h7E, 1'b1);
    tick();
    check("zlen_end_pulse", bus.pkt_end, 1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("final_ovf_clr", bus.overflow_err, 1'b0);
    check("final_udf_clr", bus.underflow_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware output FIFO for the router. It sits between the router FSM/register path and each output channel, replacing the fixed 8x16 channel FIFO. It keeps the header-marker bit per entry and tracks packet boundaries on the read side. It adds an almost-full threshold, a packet-end strobe, a read-valid strobe and optional error flags.

## Interface
- DATA_WIDTH, 8, width of data byte; header is {payload_len[DATA_WIDTH-1:2], addr[1:0]}
- DEPTH, 16, number of entries (power of two, >=4)
- ADDR_WIDTH, 4, log2(DEPTH)
- AFULL_TH, 14, almost_full asserts when occupancy >= AFULL_TH (1..DEPTH)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- soft_reset  in  1  synchronous flush, active-high
- write_enb  in  1  write request
- read_enb  in  1  read request
- lfd_state  in  1  marks data_in as packet header byte
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  one-cycle strobe, data_out updated by a read
- pkt_end  out  1  one-cycle strobe with data_valid, last byte (parity) of packet
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy >= AFULL_TH
- occupancy  out  ADDR_WIDTH+1  entries stored
- overflow_err  out  1  sticky, write attempted while full (macro-dependent)
- underflow_err  out  1  sticky, read attempted while empty (macro-dependent)

## Operation
- Storage: DEPTH x (DATA_WIDTH+1). The extra bit holds lfd_state at write time.
- Write is accepted iff write_enb && !full. It stores {lfd_state, data_in} at wr_ptr, then wr_ptr+1.
- Read is accepted iff read_enb && !empty. On the next edge, data_out = entry data, data_valid=1, rd_ptr+1.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. Occupancy is a separate counter: +1 on write only, -1 on read only, unchanged on both or neither.
- Packet tracking uses a down-counter rem_cnt, 6+ bits (DATA_WIDTH-2 bits +1).
- Reading an entry with lfd bit set loads rem_cnt = payload_len + 1.
- Each later accepted read of a non-lfd entry decrements rem_cnt. pkt_end=1 when that read has rem_cnt==1.
- A header with payload_len 0 gives a 2-entry packet (header, parity).
- A read of an lfd entry while rem_cnt != 0 (truncated packet) reloads rem_cnt without error.
- Simultaneous write and read when full: the read is accepted and the write is rejected (full is evaluated before the read). When empty, only the write is accepted.
- soft_reset priority: soft_reset > read/write. It clears the pointers, occupancy, rem_cnt, data_valid, pkt_end and data_out, and ignores same-cycle requests. Error flags are cleared only by reset.
- reset mid-operation aborts immediately. Memory contents need not be cleared.

## Timing
- Reset values: data_out=0, data_valid=0, pkt_end=0, full=0, empty=1, almost_full=0, occupancy=0, errors=0.
- Read latency: 1 cycle, from read_enb sampled to data_out/data_valid.
- full/empty/almost_full/occupancy are decoded from the registered occupancy. They update on the same edge that accepts the write/read.
- data_out holds its last value when no read is accepted. data_valid and pkt_end are single-cycle pulses.
- Back-to-back reads every cycle are supported. Throughput is 1 entry/cycle on each side.

## Configuration
- ROUTER_FIFO_ERR_EN defined: overflow_err sets on write_enb && full, and underflow_err sets on read_enb && empty. Both are sticky until reset.
- ROUTER_FIFO_ERR_EN undefined: both outputs are tied 0 and no flag logic is built.

## Test plan
- Reset: assert reset asynchronously mid-cycle. All outputs go to reset values immediately, with empty=1 and occupancy=0.
- Packet: write header 0x31 (len 12, addr 01) with lfd=1, payload 0,5,...,55, then parity 0xA5, for 14 writes and occupancy=14.
  - almost_full goes to 1 at occupancy 14.
  - Read 14 times: data_out sequence matches, data_valid on each, pkt_end only with 0xA5, empty=1 after.
- Full/wrap: write 16 entries, giving full=1. A 17th write is ignored and overflow_err=1 (macro on).
  - Simultaneous read+write while full: occupancy goes to 15 and the write is dropped.
  - Then continue writes/reads across index 15->0 with data intact.
- Soft reset mid-packet: write header 0x0D (len 3) plus 2 bytes, read 1, assert soft_reset with write_enb=1.
  - Next cycle: occupancy=0, empty=1, data_out=0, no write stored.
  - A following fresh packet reads out correctly.
- Underflow: read_enb=1 on empty gives no data_valid, data_out unchanged, underflow_err=1 (0 with macro off).
- Zero-length packet: header 0x02 then parity 0x7E. The read of 0x7E gives pkt_end=1.
